// File: rtl/prog_interval_timer.sv
// rtl/prog_interval_timer.sv - programmable one-shot/periodic interval timer with sticky done and expiry tick
// Optional TIMER_PRESCALE_EN: count steps only once every PRESCALE clk cycles.
module prog_interval_timer #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] term, term_n;
  logic [WIDTH-1:0] count_n;
  logic             mode_r, mode_n;
  logic             done_n, tick_n, busy_n;
  logic             step;

  if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
    $error("prog_interval_timer: PRESCALE must be in 1..256");
  end

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;

  assign step = (psc == PSC_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || stop || start) begin
      psc <= '0;
    end else if (state == RUN) begin
      psc <= step ? '0 : psc + PW'(1);
    end
  end
`else
  assign step = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      term   <= '0;
      mode_r <= 1'b0;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tick   <= 1'b0;
    end else begin
      state  <= state_n;
      term   <= term_n;
      mode_r <= mode_n;
      count  <= count_n;
      busy   <= busy_n;
      done   <= done_n;
      tick   <= tick_n;
    end
  end

  always_comb begin
    state_n = state;
    term_n  = term;
    mode_n  = mode_r;
    count_n = count;
    done_n  = done;
    tick_n  = 1'b0;
    if (stop) begin
      if (state != IDLE) begin
        state_n = IDLE;
        count_n = '0;
        done_n  = 1'b0;
      end
    end else if (start) begin
      state_n = RUN;
      term_n  = load_val;
      mode_n  = mode;
      count_n = '0;
      done_n  = 1'b0;
    end else if (state == RUN && step) begin
      // Compare before increment so term = all-ones never wraps.
      if (count == term) begin
        tick_n = 1'b1;
        if (mode_r) begin
          count_n = '0;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end else begin
        count_n = count + WIDTH'(1);
      end
    end
    busy_n = (state_n == RUN);
  end

endmodule

// File: tb/tb_prog_interval_timer.sv
// tb/tb_prog_interval_timer.sv - scoreboard bench for prog_interval_timer
module tb_prog_interval_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b1;
  logic       stop = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] load_val = 8'd5;
  logic [7:0] count;
  logic       busy, done, tick;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         e;
    string      name;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic       tick;
  } exp_t;

  exp_t q[$];

  prog_interval_timer #(.WIDTH(8), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .load_val(load_val), .count(count), .busy(busy), .done(done), .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor: every negedge, pop the expectations due after the edges seen so far.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= cyc) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (x.e < cyc) begin
        errors++;
        $display("FAIL %s: expectation for edge %0d missed (now %0d)", x.name, x.e, cyc);
      end else if (count !== x.cnt || busy !== x.busy || done !== x.done || tick !== x.tick) begin
        errors++;
        $display("FAIL %s edge %0d: got count=%0d busy=%b done=%b tick=%b, required count=%0d busy=%b done=%b tick=%b",
                 x.name, x.e, count, busy, done, tick, x.cnt, x.busy, x.done, x.tick);
      end
    end
  end

  function automatic void expect_at(int e, string n, int c, bit b, bit d, bit t);
    exp_t x;
    x.e = e; x.name = n; x.cnt = 8'(c); x.busy = b; x.done = d; x.tick = t;
    q.push_back(x);
  endfunction

  task automatic wait_edge(input int e);
    while (cyc < e) @(negedge clk);
  endtask

  task automatic begin_start(input logic [7:0] lv, input logic md, output int k);
    start = 1'b1; load_val = lv; mode = md;
    k = cyc + 1;
  endtask

  task automatic end_start();
    @(negedge clk);
    start = 1'b0; load_val = 8'hA5; mode = ~mode;
  endtask

  task automatic pulse_stop(output int k);
    stop = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int k, k2;

    // Reset held 3 edges with start asserted
    for (int i = 1; i <= 3; i++) expect_at(i, "reset", 0, 0, 0, 0);
    wait_edge(3);
    rst_n = 1'b1; start = 1'b0;
    wait_edge(5);

`ifdef TIMER_PRESCALE_EN
    begin_start(8'd2, 1'b0, k);
    expect_at(k,      "psc_os_c0",   0, 1, 0, 0);
    expect_at(k + 3,  "psc_os_c0b",  0, 1, 0, 0);
    expect_at(k + 4,  "psc_os_c1",   1, 1, 0, 0);
    expect_at(k + 8,  "psc_os_c2",   2, 1, 0, 0);
    expect_at(k + 11, "psc_os_pre",  2, 1, 0, 0);
    expect_at(k + 12, "psc_os_done", 2, 0, 1, 1);
    expect_at(k + 13, "psc_os_hold", 2, 0, 1, 0);
    end_start();
    wait_edge(k + 14);

    begin_start(8'd2, 1'b1, k);
    for (int j = 1; j <= 3; j++) begin
      expect_at(k + 12*j - 1, "psc_per_pre",  2, 1, 0, 0);
      expect_at(k + 12*j,     "psc_per_tick", 0, 1, 0, 1);
      expect_at(k + 12*j + 1, "psc_per_post", 0, 1, 0, 0);
    end
    end_start();
    wait_edge(k + 38);
    pulse_stop(k);
    expect_at(k, "psc_per_stop", 0, 0, 0, 0);
    wait_edge(k + 1);
`else
    // One-shot, load 5; load/mode changes after start must be ignored
    begin_start(8'd5, 1'b0, k);
    for (int i = 0; i <= 5; i++) expect_at(k + i, "os5_count", i, 1, 0, 0);
    expect_at(k + 6,  "os5_done",   5, 0, 1, 1);
    expect_at(k + 7,  "os5_ticklo", 5, 0, 1, 0);
    expect_at(k + 10, "os5_sticky", 5, 0, 1, 0);
    end_start();
    wait_edge(k + 11);

    // Periodic, load 3: tick every 4 cycles
    begin_start(8'd3, 1'b1, k);
    for (int j = 1; j <= 5; j++) begin
      expect_at(k + 4*j - 1, "per3_pre",  3, 1, 0, 0);
      expect_at(k + 4*j,     "per3_tick", 0, 1, 0, 1);
      expect_at(k + 4*j + 1, "per3_post", 1, 1, 0, 0);
    end
    end_start();
    wait_edge(k + 21);
    pulse_stop(k2);
    expect_at(k2,     "per3_stop", 0, 0, 0, 0);
    expect_at(k2 + 2, "per3_idle", 0, 0, 0, 0);
    wait_edge(k2 + 3);

    // load 0 one-shot
    begin_start(8'd0, 1'b0, k);
    expect_at(k,     "os0_run",  0, 1, 0, 0);
    expect_at(k + 1, "os0_done", 0, 0, 1, 1);
    expect_at(k + 2, "os0_hold", 0, 0, 1, 0);
    end_start();
    wait_edge(k + 3);

    // load 0 periodic ticks every cycle
    begin_start(8'd0, 1'b1, k);
    for (int i = 1; i <= 4; i++) expect_at(k + i, "per0_tick", 0, 1, 0, 1);
    end_start();
    wait_edge(k + 4);
    pulse_stop(k2);
    expect_at(k2, "per0_stop", 0, 0, 0, 0);
    wait_edge(k2 + 1);

    // load 255 one-shot: no wrap
    begin_start(8'd255, 1'b0, k);
    expect_at(k + 128, "os255_mid",  128, 1, 0, 0);
    expect_at(k + 255, "os255_term", 255, 1, 0, 0);
    expect_at(k + 256, "os255_done", 255, 0, 1, 1);
    expect_at(k + 258, "os255_hold", 255, 0, 1, 0);
    end_start();
    wait_edge(k + 259);

    // Restart in RUN at count=2 with load 4
    begin_start(8'd9, 1'b0, k);
    expect_at(k + 2, "rst_c2", 2, 1, 0, 0);
    end_start();
    wait_edge(k + 2);
    begin_start(8'd4, 1'b0, k2);
    expect_at(k2,     "restart_c0",   0, 1, 0, 0);
    expect_at(k2 + 4, "restart_c4",   4, 1, 0, 0);
    expect_at(k2 + 5, "restart_done", 4, 0, 1, 1);
    end_start();
    wait_edge(k2 + 6);

    // start in DONE clears done on that edge
    begin_start(8'd2, 1'b0, k);
    expect_at(k, "startdone_run", 0, 1, 0, 0);
    end_start();
    wait_edge(k2 + 8);

    // start and stop together while running: stop wins
    begin_start(8'd5, 1'b0, k);
    end_start();
    wait_edge(k + 2);
    start = 1'b1; load_val = 8'd7; stop = 1'b1;
    expect_at(cyc + 1, "startstop_idle", 0, 0, 0, 0);
    expect_at(cyc + 3, "startstop_stay", 0, 0, 0, 0);
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    wait_edge(k + 3);

    // stop in DONE clears done
    begin_start(8'd1, 1'b0, k);
    expect_at(k + 2, "stopdone_done", 1, 0, 1, 1);
    end_start();
    wait_edge(k + 4);
    pulse_stop(k2);
    expect_at(k2, "stopdone_idle", 0, 0, 0, 0);
    wait_edge(k2 + 1);
`endif

    wait_edge(cyc + 2);
    while (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for edge %0d never checked", x.name, x.e);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_interval_timer.md
Name: prog_interval_timer

Overview:
- Parametrised successor to the fixed-value one-shot timer used for SPI inter-frame and CS setup/hold delays.
- Runtime-loadable terminal count, start/stop control, one-shot or auto-reload (periodic) mode.
- Emits a sticky done level plus a one-cycle tick per expiry.
- Instantiated by the SPI master/slave control FSMs; SCLK generation may also use it in periodic mode.

Parameters:
- WIDTH, 8: width of load_val and count; terminal values 0..2^WIDTH-1.
- PRESCALE, 4: clk cycles per count step. Used only when TIMER_PRESCALE_EN is defined. Legal range 1..256.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  level-sampled each cycle; latches load_val/mode and (re)starts counting.
- stop  in  1  aborts the running count; returns to IDLE.
- mode  in  1  0 = one-shot, 1 = periodic auto-reload; latched on start.
- load_val  in  WIDTH  terminal count; latched on start.
- count  out  WIDTH  current count value, registered.
- busy  out  1  high while in RUN.
- done  out  1  one-shot expiry flag; sticky until start or reset.
- tick  out  1  one-cycle pulse on every expiry, both modes.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at a clk edge), dominant over all inputs:
  - state=IDLE; count=0, busy=0, done=0, tick=0.
  - Internal term/mode registers cleared.
- States:
  - IDLE: count=0, busy=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1, count holds term.
- Priority per edge: reset > stop > start > counting.
- start sampled in any state, including RUN:
  - term<=load_val, mode_r<=mode, count<=0, done<=0, tick<=0.
  - state<=RUN.
  - A start in RUN restarts from 0 with the new values.
- stop sampled:
  - In RUN: state<=IDLE, count<=0, tick<=0.
  - In DONE: state<=IDLE, count<=0, done<=0.
  - In IDLE: no effect.
  - stop and start together: stop wins; start is ignored.
- RUN, count!=term: count<=count+1.
- RUN, count==term (expiry):
  - tick<=1 for exactly one cycle.
  - One-shot: state<=DONE, done<=1, count holds term.
  - Periodic: count<=0, state stays RUN, done stays 0.
- Timing:
  - start sampled at edge k gives count=0 after edge k and count=term after edge k+term.
  - tick/done are high after edge k+term+1.
  - One-shot latency from start to done = term+2 edges.
  - Periodic tick period = term+1 cycles.
- load_val=0: expiry on the first RUN cycle; tick two edges after start. Periodic mode then ticks every cycle.
- load_val=2^WIDTH-1: no overflow, because the terminal compare precedes the increment. count never wraps past term.
- load_val and mode changes outside a start cycle are ignored.
- tick is low in IDLE and DONE, except in the single cycle following the expiry edge.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Adds an internal prescale counter of $clog2(PRESCALE) bits (min 1), cleared on start, stop and reset.
  - In RUN, count steps and expiry evaluation occur only on cycles where the prescale counter equals PRESCALE-1. The prescale counter wraps to 0 on those cycles.
  - One-shot latency becomes (term+1)*PRESCALE+1 edges; periodic tick period becomes (term+1)*PRESCALE.
  - PRESCALE=1 is identical to the undefined case.
- Undefined: no prescale logic; PRESCALE is ignored; count steps every RUN cycle.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles with start=1 -> count=0, busy=0, done=0, tick=0 throughout.
- One-shot: load_val=5, mode=0, start pulsed at edge 0 -> count 0..5 over edges 0..5; done=1 and tick=1 after edge 6; tick low after edge 7; done stays 1 and count=5 until the next start.
- Periodic: load_val=3, mode=1 -> tick every 4 cycles for 5 periods; done stays 0; stop afterwards gives busy=0 and count=0 on the next edge.
- Boundaries:
  - load_val=0, one-shot -> done after edge 2.
  - load_val=255 (WIDTH=8), one-shot -> done after edge 257, with no count wrap.
- Restart/priority:
  - start at count=2 with load_val=4 -> count returns to 0; done 6 edges later.
  - start and stop in the same cycle -> IDLE.
  - start in DONE -> done clears on that edge.
- TIMER_PRESCALE_EN, PRESCALE=4, load_val=2, one-shot -> count increments every 4 cycles; done after edge 13. Periodic mode -> tick period 12.
